// File: rtl/pe_cmd_dispatcher.sv
// Initiator side of the PE start/instruction/done handshake: queues host instructions in a
// small FIFO, issues them one at a time and tracks completion, counts and a sticky timeout.
//
// state | meaning
// IDLE  | waiting for FIFO data; pops the head into pe_instruction when non-empty
// ISSUE | pe_start pulse, wait counter cleared
// WAIT  | waiting for a rising edge on pe_done, or for the timeout to expire
module pe_cmd_dispatcher #(
   parameter int FIFO_DEPTH     = 4,
   parameter int TIMEOUT_CYCLES = 255,
   parameter int CNT_WIDTH      = 16
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          cmd_valid,
   input  logic [31:0]                   cmd_instr,
   output logic                          cmd_ready,
   output logic                          pe_start,
   output logic [31:0]                   pe_instruction,
   input  logic                          pe_done,
   output logic                          op_done,
   output logic                          busy,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
   output logic [CNT_WIDTH-1:0]          completed_count,
   output logic                          timeout_err,
   output logic [31:0]                   err_instr,
   input  logic                          err_clr
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam logic [AW:0] DEPTH_L   = (AW+1)'(FIFO_DEPTH);
   localparam logic [15:0] WAIT_LAST = 16'(TIMEOUT_CYCLES - 1);

   typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT} state_t;

   state_t        state, state_nxt;
   logic [31:0]   mem [FIFO_DEPTH];
   logic [AW-1:0] wr_ptr, rd_ptr;
   logic          push, pop;
   logic          done_q, done_rise;
   logic          timeout_fire;
   logic [15:0]   wait_cnt;

   assign cmd_ready = (fifo_level != DEPTH_L);
   assign push      = cmd_valid && cmd_ready;
   // Only a fresh rising edge counts: a done level left over from the previous op is ignored.
   assign done_rise = pe_done && !done_q;
   assign busy      = (state != S_IDLE) || (fifo_level != '0);

   always_comb begin
      state_nxt    = state;
      pop          = 1'b0;
      pe_start     = 1'b0;
      op_done      = 1'b0;
      timeout_fire = 1'b0;
      case (state)
         S_IDLE: begin
            if (fifo_level != '0) begin
               pop       = 1'b1;
               state_nxt = S_ISSUE;
            end
         end
         S_ISSUE: begin
            pe_start  = 1'b1;
            state_nxt = S_WAIT;
         end
         S_WAIT: begin
            // completion takes priority over a timeout landing on the same cycle
            if (done_rise) begin
               op_done   = 1'b1;
               state_nxt = S_IDLE;
            end else if (wait_cnt == WAIT_LAST) begin
               timeout_fire = 1'b1;
               state_nxt    = S_IDLE;
            end
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= S_IDLE;
      else        state <= state_nxt;
   end

   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= cmd_instr;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         fifo_level <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({push, pop})
            2'b10:   fifo_level <= fifo_level + 1'b1;
            2'b01:   fifo_level <= fifo_level - 1'b1;
            default: fifo_level <= fifo_level;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         done_q          <= 1'b0;
         pe_instruction  <= '0;
         wait_cnt        <= '0;
         completed_count <= '0;
         timeout_err     <= 1'b0;
         err_instr       <= '0;
      end else begin
         done_q <= pe_done;
         if (pop) pe_instruction <= mem[rd_ptr];
         if (state == S_ISSUE)     wait_cnt <= '0;
         else if (state == S_WAIT) wait_cnt <= wait_cnt + 16'd1;
         if (op_done) completed_count <= completed_count + 1'b1;
         // a new timeout overrides a simultaneous clear
         if (timeout_fire) begin
            timeout_err <= 1'b1;
            err_instr   <= pe_instruction;
         end else if (err_clr) begin
            timeout_err <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_pe_cmd_dispatcher.sv
// Self-checking bench for pe_cmd_dispatcher: instruction scoreboard plus a simple PE model
// (automatic latency / stall) or direct control of pe_done for edge-case scenarios.
module tb_pe_cmd_dispatcher;
   localparam int DEPTH = 4;
   localparam int TO    = 20;
   localparam int CW    = 16;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          cmd_valid = 1'b0;
   logic [31:0]   cmd_instr = '0;
   logic          cmd_ready;
   logic          pe_start;
   logic [31:0]   pe_instruction;
   logic          pe_done;
   logic          op_done;
   logic          busy;
   logic [2:0]    fifo_level;
   logic [CW-1:0] completed_count;
   logic          timeout_err;
   logic [31:0]   err_instr;
   logic          err_clr = 1'b0;

   // PE model controls
   logic pe_man = 1'b0, pe_done_man = 1'b0, pe_stall = 1'b0, pe_done_auto = 1'b0, pe_armed = 1'b0;
   int   pe_lat = 13;
   int   pe_cnt = 0;

   int            cyc = 0;
   int            n_cmp = 0;
   int            n_err = 0;
   int            exp_cnt = 0;
   logic [31:0]   exp_q[$];
   logic [31:0]   exp_v;

   assign pe_done = pe_man ? pe_done_man : pe_done_auto;

   pe_cmd_dispatcher #(.FIFO_DEPTH(DEPTH), .TIMEOUT_CYCLES(TO), .CNT_WIDTH(CW)) dut (
      .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_instr(cmd_instr),
      .cmd_ready(cmd_ready), .pe_start(pe_start), .pe_instruction(pe_instruction),
      .pe_done(pe_done), .op_done(op_done), .busy(busy), .fifo_level(fifo_level),
      .completed_count(completed_count), .timeout_err(timeout_err),
      .err_instr(err_instr), .err_clr(err_clr)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // PE raises done pe_lat cycles after start, drops it the cycle after it samples start
   always @(posedge clk) begin
      if (pe_start) begin
         pe_done_auto <= 1'b0;
         pe_cnt       <= pe_lat - 1;
         pe_armed     <= 1'b1;
      end else if (pe_armed && !pe_stall) begin
         if (pe_cnt == 1) begin
            pe_done_auto <= 1'b1;
            pe_armed     <= 1'b0;
         end else begin
            pe_cnt <= pe_cnt - 1;
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: time limit reached, summary not printed");
      $fatal(1, "watchdog");
   end

   task automatic step();
      @(negedge clk);
      #1;
   endtask

   task automatic push(input logic [31:0] instr);
      cmd_valid = 1'b1;
      cmd_instr = instr;
      for (int i = 0; i < 50 && !cmd_ready; i++) step();
      if (cmd_ready) exp_q.push_back(instr);
      else begin
         n_cmp++; n_err++;
         $display("FAIL push_ready: cmd_ready=%b want 1 for %h", cmd_ready, instr);
      end
      step();
      cmd_valid = 1'b0;
   endtask

   task automatic wait_start(output int s);
      s = -1;
      for (int i = 0; i < 60; i++) begin
         if (pe_start) begin
            s = cyc;
            return;
         end
         step();
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      step(); step();
      n_cmp++;
      if ({pe_start, op_done, busy, timeout_err} !== 4'b0) begin
         n_err++; $display("FAIL rst_flags: start/done/busy/err=%b want 0000", {pe_start, op_done, busy, timeout_err});
      end
      n_cmp++;
      if (fifo_level !== 3'd0 || completed_count !== '0) begin
         n_err++; $display("FAIL rst_counts: level=%0d count=%0d want 0 0", fifo_level, completed_count);
      end
      n_cmp++;
      if (pe_instruction !== 32'h0 || err_instr !== 32'h0) begin
         n_err++; $display("FAIL rst_instr: pe_instr=%h err_instr=%h want 0 0", pe_instruction, err_instr);
      end
      rst_n = 1'b1;
      step();
      n_cmp++;
      if (cmd_ready !== 1'b1) begin n_err++; $display("FAIL rst_ready: cmd_ready=%b want 1", cmd_ready); end
   endtask

   task automatic test_single_op();
      int t0, s, d;
      bit found;
      pe_man = 1'b0; pe_stall = 1'b0; pe_lat = 13;
      t0 = cyc;
      push(32'h1000_0000);
      wait_start(s);
      n_cmp++;
      if (s !== t0 + 2) begin n_err++; $display("FAIL t1_latency: start at cycle %0d want %0d", s, t0 + 2); end
      if (s >= 0) begin
         exp_v = (exp_q.size() != 0) ? exp_q.pop_front() : 32'hDEAD_BEEF;
         n_cmp++;
         if (pe_instruction !== exp_v) begin n_err++; $display("FAIL t1_instr: got %h want %h", pe_instruction, exp_v); end
      end
      found = 1'b0;
      for (int i = 0; i < 40; i++) begin
         if (op_done) begin found = 1'b1; break; end
         step();
      end
      d = cyc;
      n_cmp++;
      if (!found || d !== s + 13) begin
         n_err++; $display("FAIL t1_done_time: op_done seen=%0d at cycle %0d want 1 at %0d", found, d, s + 13);
      end
      n_cmp++;
      if (pe_instruction !== 32'h1000_0000) begin n_err++; $display("FAIL t1_hold: pe_instr=%h want 10000000", pe_instruction); end
      exp_cnt++;
      step();
      n_cmp++;
      if (op_done !== 1'b0 || busy !== 1'b0 || completed_count !== CW'(exp_cnt)) begin
         n_err++; $display("FAIL t1_after: op_done=%b busy=%b count=%0d want 0 0 %0d", op_done, busy, completed_count, exp_cnt);
      end
   endtask

   task automatic test_backpressure();
      logic [31:0] list [6];
      int idx, target;
      for (int k = 0; k < 6; k++) list[k] = 32'h2000_0001 + 32'(k);
      pe_man = 1'b0; pe_stall = 1'b1; pe_lat = 5;
      idx = 0;
      target = exp_cnt + 6;
      for (int c = 0; c < 400; c++) begin
         if (pe_start) begin
            exp_v = (exp_q.size() != 0) ? exp_q.pop_front() : 32'hDEAD_BEEF;
            n_cmp++;
            if (pe_instruction !== exp_v) begin n_err++; $display("FAIL t2_order: got %h want %h", pe_instruction, exp_v); end
         end
         if (c >= 5 && c <= 7) begin
            n_cmp++;
            if (cmd_ready !== 1'b0 || fifo_level !== 3'd4) begin
               n_err++; $display("FAIL t2_full: cycle %0d ready=%b level=%0d want 0 4", c, cmd_ready, fifo_level);
            end
         end
         if (c == 8) pe_stall = 1'b0;
         if (idx < 6) begin
            cmd_valid = 1'b1;
            cmd_instr = list[idx];
            if (cmd_ready) begin
               exp_q.push_back(list[idx]);
               idx++;
            end
         end else begin
            cmd_valid = 1'b0;
         end
         step();
         if (idx == 6 && completed_count == CW'(target)) break;
      end
      cmd_valid = 1'b0;
      exp_cnt = target;
      n_cmp++;
      if (completed_count !== CW'(exp_cnt) || exp_q.size() != 0 || idx != 6) begin
         n_err++; $display("FAIL t2_drain: count=%0d left=%0d pushed=%0d want %0d 0 6", completed_count, exp_q.size(), idx, exp_cnt);
      end
   endtask

   task automatic test_stale_done();
      int s;
      pe_man = 1'b1; pe_done_man = 1'b1;
      step();
      push(32'h4000_0003);
      wait_start(s);
      n_cmp++;
      if (s < 0) begin n_err++; $display("FAIL t3_start: pe_start not seen want 1"); end
      else begin
         exp_v = (exp_q.size() != 0) ? exp_q.pop_front() : 32'hDEAD_BEEF;
         if (pe_instruction !== exp_v) begin n_err++; $display("FAIL t3_instr: got %h want %h", pe_instruction, exp_v); end
      end
      for (int k = 0; k < 4; k++) begin
         n_cmp++;
         if (op_done !== 1'b0) begin n_err++; $display("FAIL t3_stale: cycle +%0d op_done=%b want 0", k, op_done); end
         step();
         if (k == 0) pe_done_man = 1'b0;
      end
      pe_done_man = 1'b1;
      #1;
      n_cmp++;
      if (op_done !== 1'b1) begin n_err++; $display("FAIL t3_rise: op_done=%b want 1", op_done); end
      exp_cnt++;
      step();
      n_cmp++;
      if (op_done !== 1'b0 || completed_count !== CW'(exp_cnt)) begin
         n_err++; $display("FAIL t3_once: op_done=%b count=%0d want 0 %0d", op_done, completed_count, exp_cnt);
      end
   endtask

   task automatic test_timeout();
      int s;
      pe_man = 1'b1; pe_done_man = 1'b0;
      push(32'h3000_0002);
      push(32'h3000_0003);
      wait_start(s);
      n_cmp++;
      if (s < 0) begin n_err++; $display("FAIL t4_start: pe_start not seen want 1"); end
      else begin
         exp_v = (exp_q.size() != 0) ? exp_q.pop_front() : 32'hDEAD_BEEF;
         if (pe_instruction !== exp_v) begin n_err++; $display("FAIL t4_instr: got %h want %h", pe_instruction, exp_v); end
      end
      for (int i = 0; i < 30 && cyc < s + 20; i++) step();
      n_cmp++;
      if (op_done !== 1'b0 || timeout_err !== 1'b0) begin
         n_err++; $display("FAIL t4_pre: op_done=%b timeout_err=%b want 0 0", op_done, timeout_err);
      end
      step();
      n_cmp++;
      if (timeout_err !== 1'b1 || err_instr !== 32'h3000_0002) begin
         n_err++; $display("FAIL t4_err: timeout_err=%b err_instr=%h want 1 30000002", timeout_err, err_instr);
      end
      step();
      n_cmp++;
      if (pe_start !== 1'b1) begin n_err++; $display("FAIL t4_next: pe_start=%b want 1 at 22 after start", pe_start); end
      else begin
         exp_v = (exp_q.size() != 0) ? exp_q.pop_front() : 32'hDEAD_BEEF;
         n_cmp++;
         if (pe_instruction !== exp_v) begin n_err++; $display("FAIL t4_instr2: got %h want %h", pe_instruction, exp_v); end
      end
      err_clr = 1'b1;
      step();
      err_clr = 1'b0;
      n_cmp++;
      if (timeout_err !== 1'b0 || err_instr !== 32'h3000_0002) begin
         n_err++; $display("FAIL t4_clr: timeout_err=%b err_instr=%h want 0 30000002", timeout_err, err_instr);
      end
      step();
      pe_done_man = 1'b1;
      #1;
      n_cmp++;
      if (op_done !== 1'b1) begin n_err++; $display("FAIL t4_done2: op_done=%b want 1", op_done); end
      exp_cnt++;
      step();
   endtask

   task automatic test_race_done();
      int s;
      push(32'h5000_0005);
      wait_start(s);
      n_cmp++;
      if (s < 0) begin n_err++; $display("FAIL t5_start: pe_start not seen want 1"); end
      else begin
         exp_v = (exp_q.size() != 0) ? exp_q.pop_front() : 32'hDEAD_BEEF;
         if (pe_instruction !== exp_v) begin n_err++; $display("FAIL t5_instr: got %h want %h", pe_instruction, exp_v); end
      end
      step();
      pe_done_man = 1'b0;
      for (int i = 0; i < 30 && cyc < s + 20; i++) step();
      pe_done_man = 1'b1;
      #1;
      n_cmp++;
      if (op_done !== 1'b1) begin n_err++; $display("FAIL t5_done: op_done=%b want 1 on timeout cycle", op_done); end
      exp_cnt++;
      step();
      n_cmp++;
      if (timeout_err !== 1'b0 || completed_count !== CW'(exp_cnt)) begin
         n_err++; $display("FAIL t5_noerr: timeout_err=%b count=%0d want 0 %0d", timeout_err, completed_count, exp_cnt);
      end
   endtask

   task automatic test_err_set_wins();
      int s;
      push(32'h6000_0006);
      wait_start(s);
      n_cmp++;
      if (s < 0) begin n_err++; $display("FAIL t5b_start: pe_start not seen want 1"); end
      else begin
         exp_v = (exp_q.size() != 0) ? exp_q.pop_front() : 32'hDEAD_BEEF;
         if (pe_instruction !== exp_v) begin n_err++; $display("FAIL t5b_instr: got %h want %h", pe_instruction, exp_v); end
      end
      step();
      pe_done_man = 1'b0;
      for (int i = 0; i < 30 && cyc < s + 20; i++) step();
      err_clr = 1'b1;
      step();
      err_clr = 1'b0;
      n_cmp++;
      if (timeout_err !== 1'b1 || err_instr !== 32'h6000_0006) begin
         n_err++; $display("FAIL t5b_setwins: timeout_err=%b err_instr=%h want 1 60000006", timeout_err, err_instr);
      end
      err_clr = 1'b1;
      step();
      err_clr = 1'b0;
      n_cmp++;
      if (timeout_err !== 1'b0) begin n_err++; $display("FAIL t5b_clr: timeout_err=%b want 0", timeout_err); end
   endtask

   task automatic test_reset_mid_wait();
      int s, t0;
      pe_done_man = 1'b0;
      for (int k = 1; k <= 4; k++) push(32'h7000_0000 + 32'(k));
      n_cmp++;
      if (fifo_level !== 3'd3 || busy !== 1'b1) begin
         n_err++; $display("FAIL t6_queued: level=%0d busy=%b want 3 1", fifo_level, busy);
      end
      rst_n = 1'b0;
      #1;
      n_cmp++;
      if (pe_start !== 1'b0 || fifo_level !== 3'd0 || completed_count !== '0 || busy !== 1'b0) begin
         n_err++; $display("FAIL t6_rst: start=%b level=%0d count=%0d busy=%b want 0 0 0 0", pe_start, fifo_level, completed_count, busy);
      end
      n_cmp++;
      if (err_instr !== 32'h0 || pe_instruction !== 32'h0) begin
         n_err++; $display("FAIL t6_rst_instr: err_instr=%h pe_instr=%h want 0 0", err_instr, pe_instruction);
      end
      exp_q.delete();
      exp_cnt = 0;
      step();
      rst_n = 1'b1;
      step();
      n_cmp++;
      if (cmd_ready !== 1'b1 || pe_start !== 1'b0) begin
         n_err++; $display("FAIL t6_idle: ready=%b start=%b want 1 0", cmd_ready, pe_start);
      end
      t0 = cyc;
      push(32'h7000_0007);
      wait_start(s);
      n_cmp++;
      if (s !== t0 + 2) begin n_err++; $display("FAIL t6_latency: start at %0d want %0d", s, t0 + 2); end
      if (s >= 0) begin
         exp_v = (exp_q.size() != 0) ? exp_q.pop_front() : 32'hDEAD_BEEF;
         n_cmp++;
         if (pe_instruction !== exp_v) begin n_err++; $display("FAIL t6_instr: got %h want %h", pe_instruction, exp_v); end
      end
      step(); step(); step();
      pe_done_man = 1'b1;
      #1;
      n_cmp++;
      if (op_done !== 1'b1) begin n_err++; $display("FAIL t6_done: op_done=%b want 1", op_done); end
      exp_cnt++;
      step();
      n_cmp++;
      if (completed_count !== CW'(exp_cnt) || busy !== 1'b0) begin
         n_err++; $display("FAIL t6_after: count=%0d busy=%b want %0d 0", completed_count, busy, exp_cnt);
      end
   endtask

   initial begin
      test_reset();
      test_single_op();
      test_backpressure();
      test_stale_done();
      test_timeout();
      test_race_done();
      test_err_set_wins();
      test_reset_mid_wait();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
